// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial single-port RAM controller for fetch and load/store.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_done_o,
    input  logic              mem_load_i,
    input  logic              mem_store_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [DATA_W-1:0] mem_store_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_done_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_CNT_W = $clog2(c_BYTES + 2);
    localparam int c_IDX_W = $clog2(c_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_nbytes;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_f3;
    logic [DATA_W-1:0]   r_sdata;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_if_done;
    logic                r_mem_done;
    logic [ADDR_W-1:0]   r_ram_a;
    logic [7:0]          r_ram_dout;
    logic                r_wr;

    logic                w_mem_req;
    logic [c_CNT_W-1:0]  w_req_n;
    logic [c_CNT_W-1:0]  w_step;
    logic                w_last_rd;
    logic                w_last_wr;
    logic                w_more_addr;
    logic                w_sample;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [c_IDX_W-1:0]  w_st_idx;
    logic [7:0]          w_st_byte;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_ext;

    assign w_mem_req   = mem_load_i | mem_store_i;
    // w_step is the index of the edge about to happen, counted from the accept edge
    assign w_step      = r_cnt + c_CNT_W'(1);
    assign w_last_rd   = (w_step == r_nbytes + c_CNT_W'(1));
    assign w_last_wr   = (w_step == r_nbytes);
    assign w_more_addr = (w_step < r_nbytes);
    assign w_sample    = (w_step >= c_CNT_W'(2));
    assign w_rd_idx    = c_IDX_W'(w_step - c_CNT_W'(2));
    assign w_st_idx    = c_IDX_W'(w_step);
    assign w_st_byte   = r_sdata[{w_st_idx, 3'b000} +: 8];

    always_comb begin
        w_req_n = c_CNT_W'(c_BYTES);
        case (mem_funct3_i[1:0])
            2'b00:   w_req_n = c_CNT_W'(1);
            2'b01:   w_req_n = c_CNT_W'(2);
            default: w_req_n = c_CNT_W'(c_BYTES);
        endcase
    end

    // Byte arriving on this edge merged into the partially assembled word
    always_comb begin
        w_rd_word = r_buf;
        w_rd_word[{w_rd_idx, 3'b000} +: 8] = ram_din_i;
    end

    always_comb begin
        w_ext = w_rd_word;
        case (r_f3)
            3'b000:  w_ext = {{(DATA_W-8){w_rd_word[7]}}, w_rd_word[7:0]};
            3'b100:  w_ext = {{(DATA_W-8){1'b0}}, w_rd_word[7:0]};
            3'b001:  w_ext = {{(DATA_W-16){w_rd_word[15]}}, w_rd_word[15:0]};
            3'b101:  w_ext = {{(DATA_W-16){1'b0}}, w_rd_word[15:0]};
            default: w_ext = w_rd_word;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mem_req) begin
                    w_state_nxt = mem_store_i ? ST_MEM_WR : ST_MEM_RD;
                end else if (if_req_i && !flush_i) begin
                    w_state_nxt = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_rd) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_MEM_RD: if (w_last_rd) w_state_nxt = ST_DONE;
            ST_MEM_WR: if (w_last_wr) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt      <= '0;
            r_nbytes   <= '0;
            r_addr     <= '0;
            r_f3       <= '0;
            r_sdata    <= '0;
            r_buf      <= '0;
            r_if_data  <= '0;
            r_mem_data <= '0;
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_ram_a    <= '0;
            r_ram_dout <= '0;
            r_wr       <= 1'b0;
        end else if (rdy_in) begin
            // Done pulses last exactly one enabled cycle
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_mem_req) begin
                        r_addr   <= mem_addr_i;
                        r_f3     <= mem_funct3_i;
                        r_nbytes <= w_req_n;
                        r_sdata  <= mem_store_data_i;
                        r_ram_a  <= mem_addr_i;
                        if (mem_store_i) begin
                            r_wr       <= 1'b1;
                            r_ram_dout <= mem_store_data_i[7:0];
                        end
                    end else if (if_req_i && !flush_i) begin
                        r_addr   <= if_addr_i;
                        r_nbytes <= c_CNT_W'(c_BYTES);
                        r_ram_a  <= if_addr_i;
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    r_cnt <= w_step;
                    if (w_more_addr) begin
                        r_ram_a <= r_addr + ADDR_W'(w_step);
                    end
                    if (w_sample) begin
                        r_buf <= w_rd_word;
                    end
                    if (w_last_rd) begin
                        if (r_state == ST_MEM_RD) begin
                            r_mem_data <= w_ext;
                            r_mem_done <= 1'b1;
                        end else if (!flush_i) begin
                            r_if_data <= w_rd_word;
                            r_if_done <= 1'b1;
                        end
                    end
                end
                ST_MEM_WR: begin
                    r_cnt <= w_step;
                    if (w_last_wr) begin
                        r_wr       <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_ram_a    <= r_addr + ADDR_W'(w_step);
                        r_ram_dout <= w_st_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_data_o  = r_if_data;
    assign if_done_o  = r_if_done;
    assign mem_data_o = r_mem_data;
    assign mem_done_o = r_mem_done;
    assign ram_a_o    = r_ram_a;
    assign ram_dout_o = r_ram_dout;
    // A stalled cycle must never commit a write
    assign ram_wr_o   = r_wr & rdy_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl against a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int c_RAM_SZ = 4096;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o;
    logic              mem_load_i;
    logic              mem_store_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [2:0]        mem_funct3_i;
    logic [DATA_W-1:0] mem_store_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_done_o;
    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;

    logic [7:0]  ram   [c_RAM_SZ];
    logic [7:0]  model [c_RAM_SZ];
    logic        bk_we;
    logic [11:0] bk_a;
    logic [7:0]  bk_d;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] ld_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_tab [3] = '{3'b000, 3'b001, 3'b010};

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_i          (flush_i),
        .if_req_i         (if_req_i),
        .if_addr_i        (if_addr_i),
        .if_data_o        (if_data_o),
        .if_done_o        (if_done_o),
        .mem_load_i       (mem_load_i),
        .mem_store_i      (mem_store_i),
        .mem_addr_i       (mem_addr_i),
        .mem_funct3_i     (mem_funct3_i),
        .mem_store_data_i (mem_store_data_i),
        .mem_data_o       (mem_data_o),
        .mem_done_o       (mem_done_o),
        .ram_din_i        (ram_din_i),
        .ram_dout_o       (ram_dout_o),
        .ram_a_o          (ram_a_o),
        .ram_wr_o         (ram_wr_o)
    );

    // Synchronous-read byte RAM, clock-enabled by the global ready like the rest of the pipeline
    always @(posedge clk_in) begin
        if (bk_we) begin
            ram[bk_a] <= bk_d;
        end else if (rdy_in) begin
            ram_din_i <= ram[ram_a_o[11:0]];
            if (ram_wr_o) ram[ram_a_o[11:0]] <= ram_dout_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {model[12'(a + 32'd3)], model[12'(a + 32'd2)], model[12'(a + 32'd1)], model[12'(a)]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        w = model_word(a);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        if (i >= 'h40 && i <= 'h43) return 8'h00;
        case (i)
            'h100:   return 8'h13;
            'h101:   return 8'h05;
            'h102:   return 8'h10;
            'h103:   return 8'h00;
            'h020:   return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic wait_for(input bit sel_if, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk_in); @(negedge clk_in);
            cnt++;
        end while (!(sel_if ? if_done_o : mem_done_o) && cnt < 40);
        if (!(sel_if ? if_done_o : mem_done_o)) cnt = -1;
    endtask

    // kind: 0 = fetch, 1 = load, 2 = store. Entered and left on a negedge with the block idle.
    task automatic run_access(input int kind, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] sd, input int stall_at, input bit stall_done,
                              input string tag);
        int n, lat, cnt, widx;
        bit got;
        logic [31:0] exp_data, hold_a;
        n        = (kind == 0) ? 4 : (1 << f3[1:0]);
        lat      = (kind == 2) ? n + 1 : n + 2;
        if (stall_at > 0 && stall_at < lat) lat += 3;
        exp_data = (kind == 0) ? model_word(a) : model_load(a, f3);
        if_req_i = (kind == 0);  if_addr_i = a;
        mem_load_i = (kind == 1); mem_store_i = (kind == 2);
        mem_addr_i = a; mem_funct3_i = f3; mem_store_data_i = sd;
        cnt = 0; widx = 0; got = 0;
        while (!got && cnt < 40) begin
            @(posedge clk_in); @(negedge clk_in);
            cnt++;
            if ((kind == 0) ? if_done_o : mem_done_o) begin
                got = 1;
            end else begin
                if (ram_wr_o) begin
                    check_eq({tag, " wr_addr"}, ram_a_o, a + 32'(widx));
                    check_eq({tag, " wr_byte"}, {24'h0, ram_dout_o}, {24'h0, 8'(sd >> (8 * widx))});
                    widx++;
                end
                if (cnt == stall_at) begin
                    hold_a = ram_a_o;
                    rdy_in = 1'b0;
                    repeat (3) begin
                        @(posedge clk_in); @(negedge clk_in);
                        cnt++;
                        check_eq({tag, " stall_wr"}, {31'h0, ram_wr_o}, 32'h0);
                        check_eq({tag, " stall_addr"}, ram_a_o, hold_a);
                    end
                    rdy_in = 1'b1;
                end
            end
        end
        check_eq({tag, " latency"}, got ? 32'(cnt) : 32'hFFFF_FFFF, 32'(lat));
        check_eq({tag, " wr_count"}, 32'(widx), (kind == 2) ? 32'(n) : 32'h0);
        if (kind == 0) begin
            check_eq({tag, " if_data"}, if_data_o, exp_data);
            check_eq({tag, " mem_done_idle"}, {31'h0, mem_done_o}, 32'h0);
        end else begin
            if (kind == 1) check_eq({tag, " mem_data"}, mem_data_o, exp_data);
            check_eq({tag, " if_done_idle"}, {31'h0, if_done_o}, 32'h0);
        end
        if (stall_done) begin
            rdy_in = 1'b0;
            repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
            check_eq({tag, " done_held"}, {31'h0, (kind == 0) ? if_done_o : mem_done_o}, 32'h1);
            rdy_in = 1'b1;
        end
        if_req_i = 1'b0; mem_load_i = 1'b0; mem_store_i = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        check_eq({tag, " done_pulse"}, {31'h0, (kind == 0) ? if_done_o : mem_done_o}, 32'h0);
        if (kind == 2) begin
            for (int k = 0; k < n; k++) model[12'(a + 32'(k))] = 8'(sd >> (8 * k));
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        rst_in = 1'b1; rdy_in = 1'b1; flush_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_load_i = 1'b0; mem_store_i = 1'b0; mem_addr_i = '0;
        mem_funct3_i = '0; mem_store_data_i = '0;
        bk_we = 1'b0; bk_a = '0; bk_d = '0;

        for (int i = 0; i < c_RAM_SZ; i++) begin
            @(negedge clk_in);
            bk_we = 1'b1; bk_a = 12'(i); bk_d = init_byte(i); model[i] = bk_d;
        end
        @(negedge clk_in);
        bk_we = 1'b0;

        check_eq("rst if_data",  if_data_o, 32'h0);
        check_eq("rst mem_data", mem_data_o, 32'h0);
        check_eq("rst dones",    {30'h0, if_done_o, mem_done_o}, 32'h0);
        check_eq("rst ram_wr",   {31'h0, ram_wr_o}, 32'h0);
        check_eq("rst ram_a",    ram_a_o, 32'h0);
        check_eq("rst ram_dout", {24'h0, ram_dout_o}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        run_access(0, 32'h100, 3'b010, 32'h0, 0, 0, "fetch");

        // Simultaneous fetch and LBU: the load wins, the fetch follows after DONE
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_load_i = 1'b1; mem_addr_i = 32'h20; mem_funct3_i = 3'b100;
        wait_for(1'b0, cnt);
        check_eq("arb load_lat",  32'(cnt), 32'd3);
        check_eq("arb lbu_data",  mem_data_o, 32'h0000_0080);
        check_eq("arb if_wait",   {31'h0, if_done_o}, 32'h0);
        mem_load_i = 1'b0;
        wait_for(1'b1, cnt);
        check_eq("arb fetch_lat", 32'(cnt), 32'd7);
        check_eq("arb fetch",     if_data_o, 32'h0010_0513);
        if_req_i = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        run_access(1, 32'h20, 3'b000, 32'h0, 0, 0, "lb");
        check_eq("lb sign", mem_data_o, 32'hFFFF_FF80);

        run_access(2, 32'h40, 3'b001, 32'hDEAD_BEEF, 0, 0, "sh");
        run_access(1, 32'h40, 3'b010, 32'h0, 0, 0, "lw_back");
        check_eq("lw_back value", mem_data_o, 32'h0000_BEEF);

        // Flush during the third cycle of a fetch
        if_req_i = 1'b1; if_addr_i = 32'h300;
        repeat (3) begin @(posedge clk_in); @(negedge clk_in); end
        flush_i = 1'b1; if_req_i = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        flush_i = 1'b0;
        seen = 0;
        repeat (8) begin
            if (if_done_o) seen = 1;
            @(posedge clk_in); @(negedge clk_in);
        end
        check_eq("flush no_done", {31'h0, seen}, 32'h0);

        // Fetch request alongside flush in IDLE is held off for that edge
        if_req_i = 1'b1; if_addr_i = 32'h200; flush_i = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        flush_i = 1'b0;
        wait_for(1'b1, cnt);
        check_eq("flush_idle lat",  32'(cnt), 32'd6);
        check_eq("flush_idle data", if_data_o, model_word(32'h200));
        if_req_i = 1'b0;
        @(posedge clk_in); @(negedge clk_in);

        run_access(1, 32'h100, 3'b010, 32'h0, 2, 0, "stall_lw");
        run_access(0, 32'h100, 3'b010, 32'h0, 0, 1, "done_hold");
        run_access(2, 32'hFFFF_FFFE, 3'b010, 32'hA1B2_C3D4, 3, 0, "sw_wrap");
        run_access(1, 32'hFFFF_FFFE, 3'b010, 32'h0, 0, 0, "lw_wrap");

        // Reset in the middle of a word store
        mem_store_i = 1'b1; mem_addr_i = 32'h80; mem_funct3_i = 3'b010;
        mem_store_data_i = 32'h1122_3344;
        repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
        check_eq("rst_sw pre_wr", {31'h0, ram_wr_o}, 32'h1);
        rst_in = 1'b1;
        #1;
        check_eq("rst_sw wr_drop",  {31'h0, ram_wr_o}, 32'h0);
        check_eq("rst_sw mem_data", mem_data_o, 32'h0);
        mem_store_i = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_done_o) seen = 1;
        end
        check_eq("rst_sw no_done", {31'h0, seen}, 32'h0);
        // The abandoned store left an unknown prefix of bytes behind
        for (int k = 0; k < 4; k++) model['h80 + k] = ram['h80 + k];
        run_access(0, 32'h100, 3'b010, 32'h0, 0, 0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            int kind, stall_at;
            bit sdone;
            logic [31:0] a, sd;
            logic [2:0] f3;
            kind     = $urandom_range(0, 2);
            a        = 32'($urandom_range(0, c_RAM_SZ - 1));
            sd       = $urandom;
            f3       = (kind == 2) ? st_tab[$urandom_range(0, 2)] : ld_tab[$urandom_range(0, 4)];
            stall_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            sdone    = ($urandom_range(0, 7) == 0);
            run_access(kind, a, f3, sd, stall_at, sdone, $sformatf("rnd%0d k%0d", i, kind));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
